// File: rtl/order_queue_if.sv
// Host-side bus of the order queue: load/flush controls in, current order and status out.
interface order_queue_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 9
);
  logic              clear;
  logic              mode;
  logic              push_en;
  logic [DATA_W-1:0] push_data;
  logic              pop_en;
  logic [DATA_W-1:0] order_data;
  logic              calculate_start;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  // Host / controller side
  modport master (
    output clear, mode, push_en, push_data, pop_en,
    input  order_data, calculate_start, count, full, empty, overflow, underflow
  );

  // Queue side
  modport slave (
    input  clear, mode, push_en, push_data, pop_en,
    output order_data, calculate_start, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/order_queue.sv
// Order buffer between host load path and calculation controller.
// FIFO mode consumes orders on pop; program mode keeps them and replays
// from slot 0 after the end opcode. Storage is a sync-read dual-port RAM.
module order_queue #(
  parameter int          DATA_W = 256,
  parameter int          ADDR_W = 9,
  parameter int          OP_W   = 3,
  parameter int unsigned END_OP = 5
) (
  input  logic          system_clk,
  input  logic          rst,
  order_queue_if.slave  bus
);
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [OP_W-1:0] END_CODE = OP_W'(END_OP);

  // storage; end_mark mirrors "opcode == END" per slot so the rewind
  // decision does not wait for the registered RAM read
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  end_mark;
  logic [DATA_W-1:0] rd_word_q;

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            mode_q, mode_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            cs_q, cs_d;
  logic            hide_q, hide_d;   // whole order word reads as zero
  logic            idle_q, idle_d;   // opcode field reads as zero

  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [ADDR_W:0]   count;
  logic              full, empty;
  logic              push_acc, pop_acc;
  logic [DATA_W-1:0] order_data;
  logic [OP_W-1:0]   shown_op;

  assign wr_addr = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr = rd_ptr_q[ADDR_W-1:0];

  // status from registered pointers and latched mode
  assign count    = mode_q ? wr_ptr_q : (wr_ptr_q - rd_ptr_q);
  assign full     = (count == (ADDR_W+1)'(DEPTH));
  assign empty    = (rd_ptr_q == wr_ptr_q);
  assign push_acc = bus.push_en && !full  && !bus.clear;
  assign pop_acc  = bus.pop_en  && !empty && !bus.clear;

  // visible order: RAM output register with clear and auto-idle masking
  assign order_data = hide_q ? '0
                    : {rd_word_q[DATA_W-1:OP_W], (idle_q ? {OP_W{1'b0}} : rd_word_q[OP_W-1:0])};
  assign shown_op   = order_data[OP_W-1:0];

  // RAM write port, end-mark side table and registered read port
  always_ff @(posedge system_clk) begin
    if (push_acc) begin
      mem[wr_addr]      <= bus.push_data;
      end_mark[wr_addr] <= (bus.push_data[OP_W-1:0] == END_CODE);
    end
    if (pop_acc) rd_word_q <= mem[rd_addr];
  end

  // next-state: clear dominates, then push/pop bookkeeping and auto-idle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mode_d   = mode_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    cs_d     = 1'b0;
    hide_d   = hide_q;
    idle_d   = idle_q;
    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      mode_d   = bus.mode;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      hide_d   = 1'b1;
      idle_d   = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (bus.push_en && full) ovf_d = 1'b1;
      if (bus.pop_en && empty) udf_d = 1'b1;
      if (pop_acc) begin
        cs_d     = 1'b1;
        hide_d   = 1'b0;
        idle_d   = 1'b0;
        rd_ptr_d = (mode_q && end_mark[rd_addr]) ? '0 : rd_ptr_q + 1'b1;
      end else if (shown_op == END_CODE) begin
        idle_d = 1'b1;
      end
    end
  end

  // state registers
  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mode_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      cs_q     <= 1'b0;
      hide_q   <= 1'b1;
      idle_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mode_q   <= mode_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      cs_q     <= cs_d;
      hide_q   <= hide_d;
      idle_q   <= idle_d;
    end
  end

  assign bus.order_data      = order_data;
  assign bus.calculate_start = cs_q;
  assign bus.count           = count;
  assign bus.full            = full;
  assign bus.empty           = empty;
  assign bus.overflow        = ovf_q;
  assign bus.underflow       = udf_q;
endmodule

// File: tb/tb_order_queue.sv
// Directed bench for order_queue with an 8-deep, 16-bit configuration.
module tb_order_queue;
  localparam int DW = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  order_queue_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  order_queue #(.DATA_W(DW), .ADDR_W(AW), .OP_W(3), .END_OP(5)) dut (
    .system_clk (clk),
    .rst        (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] w(input int t, input int op);
    return DW'((t << 3) | op);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock with the given request; sample #1 after the edge
  task automatic cyc(input logic pu, input logic [DW-1:0] d, input logic po);
    bus.push_en   = pu;
    bus.push_data = d;
    bus.pop_en    = po;
    @(posedge clk);
    #1;
    bus.push_en = 1'b0;
    bus.pop_en  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.clear = 1'b0; bus.mode = 1'b0;
    bus.push_en = 1'b0; bus.push_data = '0; bus.pop_en = 1'b0;
    #12;
    chk("rst_od",    32'(bus.order_data), 0);
    chk("rst_cs",    32'(bus.calculate_start), 0);
    chk("rst_cnt",   32'(bus.count), 0);
    chk("rst_full",  32'(bus.full), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_ovf",   32'(bus.overflow), 0);
    chk("rst_udf",   32'(bus.underflow), 0);
    rst = 1'b0;

    // mid-stream reset with count 3 and a live order
    for (int i = 1; i <= 4; i++) cyc(1'b1, w(i, i), 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("pre_rst_od",  32'(bus.order_data), 32'(w(1, 1)));
    chk("pre_rst_cs",  32'(bus.calculate_start), 1);
    chk("pre_rst_cnt", 32'(bus.count), 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_od",    32'(bus.order_data), 0);
    chk("mid_rst_cs",    32'(bus.calculate_start), 0);
    chk("mid_rst_cnt",   32'(bus.count), 0);
    chk("mid_rst_empty", 32'(bus.empty), 1);
    rst = 1'b0;

    // FIFO ordering and auto-idle
    cyc(1'b1, w(1, 1), 1'b0);
    cyc(1'b1, w(2, 2), 1'b0);
    cyc(1'b1, w(3, 5), 1'b0);
    chk("fifo_cnt", 32'(bus.count), 3);
    cyc(1'b0, '0, 1'b1);
    chk("fifo_od1", 32'(bus.order_data), 32'(w(1, 1)));
    chk("fifo_cs1", 32'(bus.calculate_start), 1);
    cyc(1'b0, '0, 1'b1);
    chk("fifo_od2", 32'(bus.order_data), 32'(w(2, 2)));
    chk("fifo_cs2", 32'(bus.calculate_start), 1);
    cyc(1'b0, '0, 1'b1);
    chk("fifo_od3", 32'(bus.order_data), 32'(w(3, 5)));
    chk("fifo_cs3", 32'(bus.calculate_start), 1);
    chk("fifo_empty", 32'(bus.empty), 1);
    cyc(1'b0, '0, 1'b0);
    chk("idle_od", 32'(bus.order_data), 32'(w(3, 0)));
    chk("idle_cs", 32'(bus.calculate_start), 0);

    // fill, overflow, push+pop while full
    for (int i = 0; i < 8; i++) cyc(1'b1, w(10 + i, 1), 1'b0);
    chk("full_flag", 32'(bus.full), 1);
    chk("full_cnt",  32'(bus.count), 8);
    chk("full_ovf0", 32'(bus.overflow), 0);
    cyc(1'b1, w(99, 2), 1'b0);
    chk("ovf_flag", 32'(bus.overflow), 1);
    chk("ovf_cnt",  32'(bus.count), 8);
    cyc(1'b1, w(98, 3), 1'b1);
    chk("fpp_cnt",  32'(bus.count), 7);
    chk("fpp_od",   32'(bus.order_data), 32'(w(10, 1)));
    chk("fpp_full", 32'(bus.full), 0);
    for (int i = 1; i < 8; i++) begin
      cyc(1'b0, '0, 1'b1);
      chk("drain_od", 32'(bus.order_data), 32'(w(10 + i, 1)));
    end
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_udf",   32'(bus.underflow), 0);

    // underflow and push+pop on empty
    cyc(1'b0, '0, 1'b1);
    chk("udf_cs",   32'(bus.calculate_start), 0);
    chk("udf_flag", 32'(bus.underflow), 1);
    chk("udf_od",   32'(bus.order_data), 32'(w(17, 1)));
    cyc(1'b1, w(20, 2), 1'b1);
    chk("epp_cnt", 32'(bus.count), 1);
    chk("epp_cs",  32'(bus.calculate_start), 0);

    // clear beats same-cycle push and pop
    bus.clear = 1'b1; bus.mode = 1'b0;
    cyc(1'b1, w(21, 3), 1'b1);
    bus.clear = 1'b0;
    chk("clr_cnt",   32'(bus.count), 0);
    chk("clr_ovf",   32'(bus.overflow), 0);
    chk("clr_udf",   32'(bus.underflow), 0);
    chk("clr_od",    32'(bus.order_data), 0);
    chk("clr_cs",    32'(bus.calculate_start), 0);
    chk("clr_empty", 32'(bus.empty), 1);

    // program mode replay
    bus.clear = 1'b1; bus.mode = 1'b1;
    cyc(1'b0, '0, 1'b0);
    bus.clear = 1'b0; bus.mode = 1'b0;
    cyc(1'b1, w(1, 1), 1'b0);
    cyc(1'b1, w(2, 2), 1'b0);
    cyc(1'b1, w(3, 5), 1'b0);
    chk("prog_cnt0", 32'(bus.count), 3);
    cyc(1'b0, '0, 1'b1);
    chk("prog_od1", 32'(bus.order_data), 32'(w(1, 1)));
    cyc(1'b0, '0, 1'b1);
    chk("prog_od2", 32'(bus.order_data), 32'(w(2, 2)));
    cyc(1'b0, '0, 1'b1);
    chk("prog_od3", 32'(bus.order_data), 32'(w(3, 5)));
    cyc(1'b0, '0, 1'b1);
    chk("prog_od4",   32'(bus.order_data), 32'(w(1, 1)));
    chk("prog_cs4",   32'(bus.calculate_start), 1);
    chk("prog_cnt",   32'(bus.count), 3);
    chk("prog_empty", 32'(bus.empty), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
